// File: rtl/module_muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the ALU op encodings (shared with the main datapath ALU control),
// the sequencer state encoding, the MULTU/DIVU op select values and the
// HI/LO register control codes.
package module_muldiv_sequencer_pkg;

  // ALU op encodings {binvert, op1, op0}
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operation select sampled with start
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // HI/LO register controls
  typedef enum logic [1:0] {
    HL_HOLD = 2'd0,
    HL_LOAD = 2'd1,
    HL_SHR  = 2'd2,
    HL_SHL  = 2'd3
  } hl_ctl_e;

endpackage

// File: rtl/module_muldiv_sequencer_hilo_reg.sv
// HI/LO result register pair (2 x WIDTH) with synchronous active-low clear.
// Ports:
//   clk, rst_n   : clock, synchronous active-low clear
//   ctl          : HOLD / LOAD / SHR / SHL
//   hi_d, lo_d   : load values; hi_d is also the new upper word for shifts
//   msb_d        : bit shifted into hi[WIDTH-1] on SHR (multiply carry)
//   bit_d        : bit shifted into lo[0] on SHL (quotient bit)
//   hi, lo       : register contents
module module_hilo_reg
  import module_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  hl_ctl_e          ctl,
  input  logic [WIDTH-1:0] hi_d,
  input  logic [WIDTH-1:0] lo_d,
  input  logic             msb_d,
  input  logic             bit_d,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // HI/LO update: SHR shifts {msb_d, hi_d, lo} right by one,
  // SHL replaces hi and shifts a new bit into the bottom of lo.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      case (ctl)
        HL_LOAD: begin
          hi_r <= hi_d;
          lo_r <= lo_d;
        end
        HL_SHR: begin
          hi_r <= {msb_d, hi_d[WIDTH-1:1]};
          lo_r <= {hi_d[0], lo_r[WIDTH-1:1]};
        end
        HL_SHL: begin
          hi_r <= hi_d;
          lo_r <= {lo_r[WIDTH-2:0], bit_d};
        end
        default: begin
          hi_r <= hi_r;
          lo_r <= lo_r;
        end
      endcase
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/module_muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU sequencer that borrows the shared ripple ALU.
// One shift-add (MULTU) or restoring shift-subtract (DIVU) step per RUN
// cycle, WIDTH steps per operation; the ALU is driven combinationally
// from the registered HI/LO/operand state and its result captured at the
// next edge.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start, op           : request pulse (IDLE only), 0=MULTU 1=DIVU
//   rs_val, rt_val      : operands, sampled with start
//   alu_r, alu_cout     : ALU result and MSB carry-out
//   alu_a, alu_b, aluop : ALU operands and op while running
//   alu_req, busy       : high in RUN
//   done                : one-cycle completion pulse
//   div0                : last DIVU had a zero divisor (sticky)
//   hi, lo              : result registers
module module_muldiv_sequencer
  import module_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       aluop,
  output logic             alu_req,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] count_r;
  logic             op_r;
  logic [WIDTH-1:0] operand_r;
  logic             div0_r;

  hl_ctl_e          hl_ctl_s;
  logic [WIDTH-1:0] hl_hi_d_s, hl_lo_d_s;
  logic             hl_msb_s, hl_bit_s;
  logic [WIDTH-1:0] hi_s, lo_s;

  // Divide step: remainder shifted left with the next dividend bit; the
  // bit that falls off the top means the remainder certainly exceeds the
  // divisor.
  logic [WIDTH-1:0] div_t_s;
  logic             div_m_s;
  assign div_t_s = {hi_s[WIDTH-2:0], lo_s[WIDTH-1]};
  assign div_m_s = hi_s[WIDTH-1];

  // State, counter, operand and divide-by-zero registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      op_r      <= OP_MULTU;
      operand_r <= '0;
      div0_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r      <= op;
            operand_r <= (op == OP_DIVU) ? rt_val : rs_val;
            count_r   <= '0;
            div0_r    <= (op == OP_DIVU) && (rt_val == '0);
          end else begin
            count_r <= count_r;
          end
        end
        ST_RUN:  count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Next state, ALU drive and HI/LO control.
  always_comb begin
    state_s   = state_r;
    alu_a     = '0;
    alu_b     = '0;
    aluop     = ALU_AND;
    hl_ctl_s  = HL_HOLD;
    hl_hi_d_s = hi_s;
    hl_lo_d_s = lo_s;
    hl_msb_s  = 1'b0;
    hl_bit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_RUN;
          hl_ctl_s  = HL_LOAD;
          hl_hi_d_s = '0;
          hl_lo_d_s = (op == OP_DIVU) ? rs_val : rt_val;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        alu_b = operand_r;
        if (op_r == OP_MULTU) begin
          alu_a    = hi_s;
          aluop    = ALU_ADD;
          hl_ctl_s = HL_SHR;
          if (lo_s[0]) begin
            hl_msb_s  = alu_cout;
            hl_hi_d_s = alu_r;
          end else begin
            hl_msb_s  = 1'b0;
            hl_hi_d_s = hi_s;
          end
        end else begin
          alu_a    = div_t_s;
          aluop    = ALU_SUB;
          hl_ctl_s = HL_SHL;
          // carry-out of a subtract means no borrow
          if (div_m_s || alu_cout) begin
            hl_hi_d_s = alu_r;
            hl_bit_s  = 1'b1;
          end else begin
            hl_hi_d_s = div_t_s;
            hl_bit_s  = 1'b0;
          end
        end
        if (count_r == CNT_W'(WIDTH-1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  module_hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (hl_ctl_s),
    .hi_d  (hl_hi_d_s),
    .lo_d  (hl_lo_d_s),
    .msb_d (hl_msb_s),
    .bit_d (hl_bit_s),
    .hi    (hi_s),
    .lo    (lo_s)
  );

  assign busy    = (state_r == ST_RUN);
  assign alu_req = busy;
  assign done    = (state_r == ST_DONE);
  assign div0    = div0_r;
  assign hi      = hi_s;
  assign lo      = lo_s;

endmodule

// File: tb/tb_module_muldiv_sequencer.sv
// Bench for module_muldiv_sequencer: a behavioural ALU closes the loop,
// results are compared against plain 64-bit multiply and integer divide.
module tb_module_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n, start, op;
  logic [WIDTH-1:0] rs_val, rt_val, alu_r;
  logic             alu_cout;
  logic [WIDTH-1:0] alu_a, alu_b, hi, lo;
  logic [2:0]       aluop;
  logic             alu_req, busy, done, div0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  module_muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .alu_r(alu_r), .alu_cout(alu_cout),
    .alu_a(alu_a), .alu_b(alu_b), .aluop(aluop), .alu_req(alu_req),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  // behavioural 32-bit ALU
  logic [WIDTH:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (aluop)
      3'b000:  alu_sum = {1'b0, alu_a & alu_b};
      3'b001:  alu_sum = {1'b0, alu_a | alu_b};
      3'b010:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default: alu_sum = '0;
    endcase
    alu_r    = alu_sum[WIDTH-1:0];
    alu_cout = alu_sum[WIDTH];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference results
  task automatic ref_model(input logic o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] e_hi, output logic [31:0] e_lo);
    logic [63:0] p;
    if (o == 1'b0) begin
      p = {32'd0, a} * {32'd0, b};
      e_hi = p[63:32];
      e_lo = p[31:0];
    end else if (b == 32'd0) begin
      e_hi = a;
      e_lo = 32'hFFFF_FFFF;
    end else begin
      e_hi = a % b;
      e_lo = a / b;
    end
  endtask

  // Called just after a rising edge (+1). poke1/poke2 are iteration
  // indices at which a stray start is raised; abort_at resets mid-run.
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input int poke1, input int poke2, input int abort_at);
    logic [31:0] e_hi, e_lo;
    int lat, busy_cnt, bad;
    ref_model(o, a, b, e_hi, e_lo);
    start = 1'b1; op = o;
    rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    rs_val = $urandom; rt_val = $urandom;
    check_eq("div0_at_start", {63'd0, div0}, {63'd0, (o && b == 32'd0)});
    lat = 1; busy_cnt = 0; bad = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (alu_req !== busy) bad++;
      if (busy && aluop !== (o ? 3'b110 : 3'b010)) bad++;
      if (busy && (busy_cnt - 1 == poke1 || busy_cnt - 1 == poke2)) begin
        start = 1'b1; op = ~o;
      end
      if (busy && busy_cnt - 1 == abort_at) rst_n = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      if (rst_n == 1'b0) begin
        rst_n = 1'b1;
        check_eq("abort_busy", {61'd0, busy, done, alu_req}, 64'd0);
        check_eq("abort_hilo", {hi, lo}, 64'd0);
        check_eq("abort_alu", {alu_a, alu_b} | {61'd0, aluop}, 64'd0);
        check_eq("abort_div0", {63'd0, div0}, 64'd0);
        return;
      end
      lat++;
    end
    check_eq("done_latency", lat, 33);
    check_eq("busy_cycles", busy_cnt, 32);
    check_eq("ctl_during_run", bad, 0);
    check_eq("busy_at_done", {63'd0, busy}, 64'd0);
    check_eq(o ? "div_result" : "mul_result", {hi, lo}, {e_hi, e_lo});
    check_eq("div0_at_done", {63'd0, div0}, {63'd0, (o && b == 32'd0)});
    @(posedge clk); #1;
    check_eq("done_one_cycle", {62'd0, done, busy}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("hilo_hold", {hi, lo}, {e_hi, e_lo});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; op = 1'b0;
    rs_val = 32'd5; rt_val = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("reset_flags", {59'd0, busy, done, alu_req, div0, 1'b0}, 64'd0);
    check_eq("reset_hilo", {hi, lo}, 64'd0);
    check_eq("reset_alu", {alu_a, alu_b} | {61'd0, aluop}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_after_reset", {63'd0, busy}, 64'd0);

    do_op(1'b0, 32'd6, 32'd7, -1, -1, -1);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    do_op(1'b1, 32'd100, 32'd7, -1, -1, -1);
    do_op(1'b1, 32'h8000_0000, 32'd3, -1, -1, -1);
    do_op(1'b1, 32'h1234_5678, 32'd0, -1, -1, -1);
    do_op(1'b0, 32'd12345, 32'd678, -1, -1, -1);
    do_op(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5, 31, -1);
    do_op(1'b1, 32'hCAFE_BABE, 32'd977, -1, -1, 10);
    do_op(1'b1, 32'hCAFE_BABE, 32'd977, -1, -1, -1);
    do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0:       b = b >> $urandom_range(1, 31);
        1:       b = 32'd0;
        2:       a = 32'hFFFF_FFFF;
        default: a = a;
      endcase
      do_op(1'($urandom_range(0, 1)), a, b, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
